// File: rtl/loader_write_fifo_if.sv
// -----------------------------------------------------------------------------
// loader_write_fifo_if
// Bus bundle between game_loader / top-level and loader_write_fifo.
//   master : loader side; drives flush, in_write, in_addr, in_data, nes_ce and
//            observes the SDRAM-facing outputs and the status flags.
//   slave  : the FIFO itself.
// Signals:
//   flush      synchronous clear of FIFO, outputs, overflow and checksum
//   in_write   one-cycle write strobe; in_addr/in_data sampled with it
//   nes_ce     NES clock-enable phase counter
//   out_write  SDRAM write enable, held for one nes_ce period
//   out_addr   SDRAM write address
//   out_data   SDRAM write data
//   level      occupancy 0..DEPTH
//   full       level == DEPTH
//   empty      level == 0
//   overflow   sticky: a strobe was dropped
//   busy       !empty || out_write
//   checksum   16-bit sum of issued data (zero unless checksum build)
// -----------------------------------------------------------------------------
interface loader_write_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
);
  logic                     flush;
  logic                     in_write;
  logic [ADDR_W-1:0]        in_addr;
  logic [DATA_W-1:0]        in_data;
  logic [1:0]               nes_ce;
  logic                     out_write;
  logic [ADDR_W-1:0]        out_addr;
  logic [DATA_W-1:0]        out_data;
  logic [$clog2(DEPTH):0]   level;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     busy;
  logic [15:0]              checksum;

  modport master (
    output flush, in_write, in_addr, in_data, nes_ce,
    input  out_write, out_addr, out_data, level, full, empty, overflow, busy,
           checksum
  );

  modport slave (
    input  flush, in_write, in_addr, in_data, nes_ce,
    output out_write, out_addr, out_data, level, full, empty, overflow, busy,
           checksum
  );
endinterface

// File: rtl/loader_write_fifo.sv
// -----------------------------------------------------------------------------
// loader_write_fifo
// Buffers ROM bytes coming from game_loader and replays them to SDRAM port A,
// one entry per NES memory slot (nes_ce == CE_SLOT). Each issued write is held
// stable until the next slot, i.e. one full 4-cycle nes_ce period. Lets the
// SPI loader burst bytes faster than the NES slot rate.
//
// Ports:
//   clk    system clock (NES clock domain)
//   reset  asynchronous, active-high reset
//   bus    loader_write_fifo_if.slave (see interface file for signal list)
//
// Build option:
//   LOADER_FIFO_CHECKSUM_EN  when defined, checksum is a 16-bit wrap-around
//                            sum of every issued data byte; otherwise it is
//                            tied to zero and no adder exists.
// -----------------------------------------------------------------------------
module loader_write_fifo #(
  parameter int         DEPTH   = 16,
  parameter int         ADDR_W  = 22,
  parameter int         DATA_W  = 8,
  parameter logic [1:0] CE_SLOT = 2'd3
) (
  input  logic                clk,
  input  logic                reset,
  loader_write_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  // Storage has no reset so it can map onto distributed RAM.
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic              r_out_write;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  logic              w_issue;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [ENT_W-1:0]  w_head;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_issue = (bus.nes_ce == CE_SLOT);
  assign w_pop   = w_issue && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push  = bus.in_write && (!w_full || w_pop);
  assign w_drop  = bus.in_write && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push && !bus.flush)
      r_mem[r_wptr] <= {bus.in_addr, bus.in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // Outputs only move in issue cycles, so they stay put for a whole slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_write <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else if (bus.flush) begin
      r_out_write <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else if (w_issue) begin
      if (w_pop) begin
        r_out_write              <= 1'b1;
        {r_out_addr, r_out_data} <= w_head;
      end else begin
        r_out_write <= 1'b0;
      end
    end
  end

`ifdef LOADER_FIFO_CHECKSUM_EN
  logic [15:0] r_checksum;

  function automatic logic [15:0] f_csum_add(input logic [15:0] acc,
                                             input logic [DATA_W-1:0] d);
    logic [15:0] ext;
    ext = '0;
    for (int i = 0; i < DATA_W && i < 16; i++)
      ext[i] = d[i];
    return acc + ext;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_checksum <= '0;
    else if (bus.flush)
      r_checksum <= '0;
    else if (w_pop)
      r_checksum <= f_csum_add(r_checksum, w_head[DATA_W-1:0]);
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = 16'h0000;
`endif

  assign bus.out_write = r_out_write;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.level     = r_level;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = !w_empty || r_out_write;

endmodule
